// File: rtl/mrb_pkg.sv
// Shared definitions for the parametrised matrix register bank (mtxregb_v2).
package mrb_pkg;

    localparam int MRB_RD_LAT = 3;

    typedef enum logic {
        MRB_RD_SCALAR = 1'b0,
        MRB_RD_VECTOR = 1'b1
    } mrb_rd_type_e;

    // Flat lane number of element (h,v) inside a word, h-major.
    function automatic int lane_idx(input int h, input int v, input int v_paral);
        return h * v_paral + v;
    endfunction

endpackage

// File: rtl/mrb_bank.sv
// One matrix register bank: simple dual-port RAM with per-lane write enables
// and a registered read port. Contents are never reset.
module mrb_bank
    import mrb_pkg::*;
#(
    parameter int ADDR_WTH = 9,
    parameter int LANE_WTH = 8,
    parameter int LANE_NUM = 64
) (
    input  logic                         clk_i,
    input  logic [LANE_NUM-1:0]          lane_we,
    input  logic [ADDR_WTH-1:0]          waddr,
    input  logic [LANE_WTH*LANE_NUM-1:0] wdata,
    input  logic                         re,
    input  logic [ADDR_WTH-1:0]          raddr,
    output logic [LANE_WTH*LANE_NUM-1:0] rdata
);

    localparam int DW = LANE_WTH * LANE_NUM;

    logic [DW-1:0] mem [1 << ADDR_WTH];
    logic [DW-1:0] rdata_reg;

    // Read returns the pre-write contents on an address collision; the top merges.
    always_ff @(posedge clk_i) begin
        for (int l = 0; l < LANE_NUM; l++) begin
            if (lane_we[l]) begin
                mem[waddr][l*LANE_WTH +: LANE_WTH] <= wdata[l*LANE_WTH +: LANE_WTH];
            end
        end
        if (re) begin
            rdata_reg <= mem[raddr];
        end
    end

    assign rdata = rdata_reg;

endmodule

// File: rtl/mtxregb_v2.sv
// Parametrised matrix register bank: strobed writes, scalar/vector reads with
// same-cycle forwarding, range checking and a 3-stage resettable read pipeline.
module mtxregb_v2
    import mrb_pkg::*;
#(
    parameter int  MRB_BANK_NUM    = 8,
    parameter int  MRB_IND_WTH     = 4,
    parameter int  MRB_ADDR_WTH    = 9,
    parameter int  MR_PROC_WTH     = 8,
    parameter int  MR_PROC_H_PARAL = 8,
    parameter int  MR_PROC_V_PARAL = 8,
    localparam int MR_DATA_WTH     = MR_PROC_WTH * MR_PROC_H_PARAL * MR_PROC_V_PARAL,
    localparam int VMR_DATA_WTH    = MR_DATA_WTH * MRB_BANK_NUM
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       mpu_mrb__re_i,
    input  logic                       mpu_mrb__type_i,
    input  logic [MRB_IND_WTH-1:0]     mpu_mrb__rindex_i,
    input  logic [MRB_ADDR_WTH-1:0]    mpu_mrb__raddr_i,
    output logic [MR_DATA_WTH-1:0]     mpu_mrb__rdata_o,
    output logic                       mpu_mrb__rdata_act_o,
    output logic [VMR_DATA_WTH-1:0]    mpu_mrb__vmode_rdata_o,
    output logic                       mpu_mrb__vmode_rdata_act_o,
    input  logic                       ldmr_mrb__we_i,
    input  logic [MRB_IND_WTH-1:0]     ldmr_mrb__windex_i,
    input  logic [MRB_ADDR_WTH-1:0]    ldmr_mrb__waddr_i,
    input  logic [MR_DATA_WTH-1:0]     ldmr_mrb__wdata_i,
    input  logic [MR_PROC_H_PARAL-1:0] ldmr_mrb__wstrb_h_i,
    input  logic [MR_PROC_V_PARAL-1:0] ldmr_mrb__wstrb_v_i,
    output logic                       mrb__err_o,
    input  logic                       mrb__err_clr_i
);

    localparam int LANE_NUM = MR_PROC_H_PARAL * MR_PROC_V_PARAL;
    localparam logic [MRB_IND_WTH:0] BANK_NUM_C = (MRB_IND_WTH + 1)'(MRB_BANK_NUM);

    mrb_rd_type_e rd_type;
    logic [LANE_NUM-1:0] strb_lane;

    logic [MRB_RD_LAT-1:0] s_act_sr_reg, v_act_sr_reg;
    logic [MRB_IND_WTH-1:0] rd_idx0_reg, wr_idx0_reg, rd_idx1_reg;
    logic [MRB_ADDR_WTH-1:0] rd_addr0_reg, wr_addr0_reg;
    logic wr_vld0_reg;
    logic [MR_DATA_WTH-1:0] wr_data0_reg, wr_data1_reg;
    logic [LANE_NUM-1:0] wr_lane0_reg, wr_lane1_reg;
    logic rd_oor0, wr_oor0, rd_oor1_reg, err_set, rd_vld0;
    logic [MRB_BANK_NUM-1:0] wr_hit0, fwd_hit1_reg;

    logic [LANE_NUM-1:0]    bank_we    [MRB_BANK_NUM];
    logic [MR_DATA_WTH-1:0] bank_rdata [MRB_BANK_NUM];
    logic [MR_DATA_WTH-1:0] merged     [MRB_BANK_NUM];
    logic [MR_DATA_WTH-1:0] wr_mask1, rdata_next, rdata_reg;
    logic [VMR_DATA_WTH-1:0] vmode_next, vmode_reg;
    logic err_reg;

    assign rd_type = mrb_rd_type_e'(mpu_mrb__type_i);

    for (genvar gi = 0; gi < MR_PROC_H_PARAL; gi++) begin : g_strb_h
        for (genvar gj = 0; gj < MR_PROC_V_PARAL; gj++) begin : g_strb_v
            localparam int LI = lane_idx(gi, gj, MR_PROC_V_PARAL);
            assign strb_lane[LI] = ldmr_mrb__wstrb_h_i[gi] & ldmr_mrb__wstrb_v_i[gj];
        end
    end

    // Stage 0: request capture; act shift registers carry the read valids to the outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s_act_sr_reg <= '0;
            v_act_sr_reg <= '0;
            rd_idx0_reg  <= '0;
            rd_addr0_reg <= '0;
            wr_vld0_reg  <= 1'b0;
            wr_idx0_reg  <= '0;
            wr_addr0_reg <= '0;
            wr_data0_reg <= '0;
            wr_lane0_reg <= '0;
        end else begin
            s_act_sr_reg <= {s_act_sr_reg[MRB_RD_LAT-2:0], mpu_mrb__re_i && (rd_type == MRB_RD_SCALAR)};
            v_act_sr_reg <= {v_act_sr_reg[MRB_RD_LAT-2:0], mpu_mrb__re_i && (rd_type == MRB_RD_VECTOR)};
            rd_idx0_reg  <= mpu_mrb__rindex_i;
            rd_addr0_reg <= mpu_mrb__raddr_i;
            wr_vld0_reg  <= ldmr_mrb__we_i;
            wr_idx0_reg  <= ldmr_mrb__windex_i;
            wr_addr0_reg <= ldmr_mrb__waddr_i;
            wr_data0_reg <= ldmr_mrb__wdata_i;
            wr_lane0_reg <= strb_lane & {LANE_NUM{ldmr_mrb__we_i}};
        end
    end

    assign rd_vld0 = s_act_sr_reg[0] | v_act_sr_reg[0];
    assign rd_oor0 = ({1'b0, rd_idx0_reg} >= BANK_NUM_C);
    assign wr_oor0 = ({1'b0, wr_idx0_reg} >= BANK_NUM_C);
    assign err_set = (wr_vld0_reg & wr_oor0) | (s_act_sr_reg[0] & rd_oor0);

    // An out-of-range write index matches no bank, so the write simply vanishes.
    for (genvar gi = 0; gi < MRB_BANK_NUM; gi++) begin : g_bank
        assign wr_hit0[gi] = wr_vld0_reg && (wr_idx0_reg == MRB_IND_WTH'(gi));
        assign bank_we[gi] = wr_lane0_reg & {LANE_NUM{wr_hit0[gi]}};

        mrb_bank #(
            .ADDR_WTH (MRB_ADDR_WTH),
            .LANE_WTH (MR_PROC_WTH),
            .LANE_NUM (LANE_NUM)
        ) u_bank (
            .clk_i   (clk_i),
            .lane_we (bank_we[gi]),
            .waddr   (wr_addr0_reg),
            .wdata   (wr_data0_reg),
            .re      (rd_vld0),
            .raddr   (rd_addr0_reg),
            .rdata   (bank_rdata[gi])
        );

        assign merged[gi] = fwd_hit1_reg[gi]
                          ? ((wr_data1_reg & wr_mask1) | (bank_rdata[gi] & ~wr_mask1))
                          : bank_rdata[gi];
        assign vmode_next[gi*MR_DATA_WTH +: MR_DATA_WTH] = merged[gi];
    end

    for (genvar gi = 0; gi < LANE_NUM; gi++) begin : g_mask
        assign wr_mask1[gi*MR_PROC_WTH +: MR_PROC_WTH] = {MR_PROC_WTH{wr_lane1_reg[gi]}};
    end

    // Stage 1: forward compare alongside the RAM read.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_idx1_reg  <= '0;
            rd_oor1_reg  <= 1'b0;
            fwd_hit1_reg <= '0;
            wr_data1_reg <= '0;
            wr_lane1_reg <= '0;
        end else begin
            rd_idx1_reg  <= rd_idx0_reg;
            rd_oor1_reg  <= rd_oor0;
            fwd_hit1_reg <= wr_hit0 & {MRB_BANK_NUM{wr_addr0_reg == rd_addr0_reg}};
            wr_data1_reg <= wr_data0_reg;
            wr_lane1_reg <= wr_lane0_reg;
        end
    end

    always_comb begin
        rdata_next = '0;
        for (int i = 0; i < MRB_BANK_NUM; i++) begin
            if (!rd_oor1_reg && (rd_idx1_reg == MRB_IND_WTH'(i))) begin
                rdata_next = merged[i];
            end
        end
    end

    // Stage 2: each data output only moves for its own mode.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_reg <= '0;
            vmode_reg <= '0;
            err_reg   <= 1'b0;
        end else begin
            if (s_act_sr_reg[MRB_RD_LAT-2]) begin
                rdata_reg <= rdata_next;
            end
            if (v_act_sr_reg[MRB_RD_LAT-2]) begin
                vmode_reg <= vmode_next;
            end
            if (err_set) begin
                err_reg <= 1'b1;
            end else if (mrb__err_clr_i) begin
                err_reg <= 1'b0;
            end
        end
    end

    assign mpu_mrb__rdata_o           = rdata_reg;
    assign mpu_mrb__rdata_act_o       = s_act_sr_reg[MRB_RD_LAT-1];
    assign mpu_mrb__vmode_rdata_o     = vmode_reg;
    assign mpu_mrb__vmode_rdata_act_o = v_act_sr_reg[MRB_RD_LAT-1];
    assign mrb__err_o                 = err_reg;

endmodule

// File: tb/tb_mtxregb_v2.sv
// Scoreboard bench for mtxregb_v2: an 8-bank instance for the data paths and a
// 6-bank instance for the out-of-range behaviour.
module tb_mtxregb_v2;

    typedef struct packed {
        logic         re;
        logic         typ;
        logic [3:0]   ridx;
        logic [8:0]   raddr;
        logic         we;
        logic [3:0]   widx;
        logic [8:0]   waddr;
        logic [511:0] wdata;
        logic [7:0]   sh;
        logic [7:0]   sv;
        logic         clr;
    } req_t;

    typedef struct {
        int unsigned   stamp;
        bit            vec;
        logic [4095:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    req_t rq [2];
    int unsigned cyc = 0;
    int n_tests = 0;
    int n_fail  = 0;
    exp_t q8[$];
    exp_t q6[$];
    logic [511:0] last_s [2];

    logic [511:0]  rdata8, rdata6;
    logic [4095:0] vdata8;
    logic [3071:0] vdata6;
    logic ract8, vact8, err8, ract6, vact6, err6;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mtxregb_v2 u_dut8 (
        .clk_i(clk), .rst_i(rst),
        .mpu_mrb__re_i(rq[0].re), .mpu_mrb__type_i(rq[0].typ),
        .mpu_mrb__rindex_i(rq[0].ridx), .mpu_mrb__raddr_i(rq[0].raddr),
        .mpu_mrb__rdata_o(rdata8), .mpu_mrb__rdata_act_o(ract8),
        .mpu_mrb__vmode_rdata_o(vdata8), .mpu_mrb__vmode_rdata_act_o(vact8),
        .ldmr_mrb__we_i(rq[0].we), .ldmr_mrb__windex_i(rq[0].widx),
        .ldmr_mrb__waddr_i(rq[0].waddr), .ldmr_mrb__wdata_i(rq[0].wdata),
        .ldmr_mrb__wstrb_h_i(rq[0].sh), .ldmr_mrb__wstrb_v_i(rq[0].sv),
        .mrb__err_o(err8), .mrb__err_clr_i(rq[0].clr)
    );

    mtxregb_v2 #(.MRB_BANK_NUM(6)) u_dut6 (
        .clk_i(clk), .rst_i(rst),
        .mpu_mrb__re_i(rq[1].re), .mpu_mrb__type_i(rq[1].typ),
        .mpu_mrb__rindex_i(rq[1].ridx), .mpu_mrb__raddr_i(rq[1].raddr),
        .mpu_mrb__rdata_o(rdata6), .mpu_mrb__rdata_act_o(ract6),
        .mpu_mrb__vmode_rdata_o(vdata6), .mpu_mrb__vmode_rdata_act_o(vact6),
        .ldmr_mrb__we_i(rq[1].we), .ldmr_mrb__windex_i(rq[1].widx),
        .ldmr_mrb__waddr_i(rq[1].waddr), .ldmr_mrb__wdata_i(rq[1].wdata),
        .ldmr_mrb__wstrb_h_i(rq[1].sh), .ldmr_mrb__wstrb_v_i(rq[1].sv),
        .mrb__err_o(err6), .mrb__err_clr_i(rq[1].clr)
    );

    function automatic logic [511:0] rep(input logic [7:0] b);
        return {64{b}};
    endfunction

    task automatic chk(input string nm, input logic [4095:0] act, input logic [4095:0] exp);
        int k;
        k = 0;
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            for (int i = 63; i >= 0; i--) begin
                if (act[i*64 +: 64] !== exp[i*64 +: 64]) k = i;
            end
            $display("[TB] FAIL %s: got %h required %h (64-bit chunk %0d)",
                     nm, act[k*64 +: 64], exp[k*64 +: 64], k);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            rq[d].re  = 1'b0;
            rq[d].we  = 1'b0;
            rq[d].clr = 1'b0;
        end
    endtask

    task automatic wr(input int d, input int idx, input int addr, input logic [511:0] data,
                      input logic [7:0] sh = 8'hFF, input logic [7:0] sv = 8'hFF);
        rq[d].we    = 1'b1;
        rq[d].widx  = 4'(idx);
        rq[d].waddr = 9'(addr);
        rq[d].wdata = data;
        rq[d].sh    = sh;
        rq[d].sv    = sv;
    endtask

    // Issue a read in the current cycle; its result is due three edges later.
    task automatic rd(input int d, input int idx, input int addr, input bit vec,
                      input logic [4095:0] exp);
        exp_t e;
        rq[d].re    = 1'b1;
        rq[d].typ   = vec;
        rq[d].ridx  = 4'(idx);
        rq[d].raddr = 9'(addr);
        e.stamp = cyc + 3;
        e.vec   = vec;
        e.data  = exp;
        if (d == 0) q8.push_back(e);
        else        q6.push_back(e);
    endtask

    task automatic mon(input int d, input logic sact, input logic vact,
                       input logic [511:0] rdv, input logic [4095:0] vdv);
        exp_t e;
        string nm;
        if (!sact && !vact) return;
        nm = (d == 0) ? "dut8" : "dut6";
        if ((d == 0 && q8.size() == 0) || (d == 1 && q6.size() == 0)) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL %s_unexpected_act: got act s=%0b v=%0b at cycle %0d, required no act",
                     nm, sact, vact, cyc);
            return;
        end
        if (d == 0) e = q8.pop_front();
        else        e = q6.pop_front();
        chk({nm, "_latency"}, 4096'(cyc), 4096'(e.stamp));
        chk({nm, "_act_mode"}, 4096'({sact, vact}), 4096'(e.vec ? 2'b01 : 2'b10));
        if (e.vec) begin
            chk({nm, "_vdata"}, vdv, e.data);
            chk({nm, "_rdata_hold"}, 4096'(rdv), 4096'(last_s[d]));
        end else begin
            chk({nm, "_rdata"}, 4096'(rdv), e.data);
            last_s[d] = e.data[511:0];
        end
        $display("[TB] %s %s read due cycle %0d checked at cycle %0d",
                 nm, e.vec ? "vector" : "scalar", e.stamp, cyc);
    endtask

    always @(negedge clk) begin
        mon(0, ract8, vact8, rdata8, vdata8);
        mon(1, ract6, vact6, rdata6, 4096'(vdata6));
    end

    initial begin
        logic [4095:0] ve;
        rq[0] = '0;
        rq[1] = '0;
        last_s[0] = '0;
        last_s[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rdata", 4096'(rdata8), '0);
        chk("rst_vdata", vdata8, '0);
        chk("rst_acts", 4096'({ract8, vact8, ract6, vact6}), '0);
        chk("rst_err", 4096'({err8, err6}), '0);
        rst = 1'b0;
        tick();

        // Full-strobe write, then scalar read.
        wr(0, 2, 5, rep(8'hA5)); tick();
        rd(0, 2, 5, 0, 4096'(rep(8'hA5))); tick();

        // Single-lane strobe (h=0, v=7) over a 0x11 background.
        wr(0, 1, 0, rep(8'h11)); tick();
        wr(0, 1, 0, rep(8'hFF), 8'h01, 8'h80); tick();
        rd(0, 1, 0, 0, 4096'({{56{8'h11}}, 8'hFF, {7{8'h11}}})); tick();

        // Same-cycle write + read: full strobes, then lower half of h lanes.
        wr(0, 3, 7, '0); tick();
        wr(0, 3, 7, rep(8'h22)); rd(0, 3, 7, 0, 4096'(rep(8'h22))); tick();
        wr(0, 3, 7, rep(8'h33), 8'h0F, 8'hFF);
        rd(0, 3, 7, 0, 4096'({{32{8'h22}}, {32{8'h33}}})); tick();

        // Vector read across all eight banks.
        ve = '0;
        for (int i = 0; i < 8; i++) begin
            wr(0, i, 9, rep(8'(i + 1))); tick();
            ve[i*512 +: 512] = rep(8'(i + 1));
        end
        rd(0, 0, 9, 1, ve); tick();

        // Six-bank instance: dropped out-of-range write, zero scalar read, sticky flag.
        ve = '0;
        for (int i = 0; i < 6; i++) begin
            wr(1, i, 2, rep(8'(8'h60 + i))); tick();
            ve[i*512 +: 512] = rep(8'(8'h60 + i));
        end
        chk("dut6_err_before", 4096'(err6), '0);
        wr(1, 7, 2, rep(8'h77)); tick();
        rd(1, 0, 2, 1, ve); tick();
        repeat (2) tick();
        chk("dut6_err_set_wr", 4096'(err6), 4096'(1));
        rq[1].clr = 1'b1; tick();
        chk("dut6_err_clr1", 4096'(err6), '0);
        rd(1, 6, 2, 0, '0); tick();
        repeat (3) tick();
        chk("dut6_err_set_rd", 4096'(err6), 4096'(1));
        rq[1].clr = 1'b1; tick();
        chk("dut6_err_clr2", 4096'(err6), '0);
        chk("dut8_err_clean", 4096'(err8), '0);

        // Reset with reads in flight: nothing may emerge afterwards.
        rd(0, 2, 5, 0, 4096'(rep(8'hA5))); tick();
        rd(0, 1, 0, 0, '0);
        rst = 1'b1;
        #1;
        q8.delete();
        q6.delete();
        last_s[0] = '0;
        last_s[1] = '0;
        chk("midrst_rdata", 4096'(rdata8), '0);
        chk("midrst_vdata", vdata8, '0);
        chk("midrst_acts", 4096'({ract8, vact8}), '0);
        tick();
        rd(0, 3, 7, 0, '0); tick();
        q8.delete();
        rst = 1'b0;
        repeat (6) tick();

        // Back-to-back reads after reset.
        rd(0, 2, 5, 0, 4096'(rep(8'hA5))); tick();
        rd(0, 1, 0, 0, 4096'({{56{8'h11}}, 8'hFF, {7{8'h11}}})); tick();
        rd(0, 3, 7, 0, 4096'({{32{8'h22}}, {32{8'h33}}})); tick();
        repeat (6) tick();

        chk("dut8_drain", 4096'(q8.size()), '0);
        chk("dut6_drain", 4096'(q6.size()), '0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mtxregb_v2.md
# mtxregb_v2

Parametrised matrix register bank for the HPU core, the successor to the fixed 8-bank, 8x8 matrix register bank. It stores matrix tiles written by the load-mtxreg controller and serves them to the MPU. The bank count, depth, lane geometry and element width are all parameters. New relative to the previous generation:

- per-lane write strobes that actually mask writes;
- same-cycle read-after-write forwarding;
- out-of-range index detection with a sticky error flag;
- a fully resettable read-valid pipeline.

## Interface
Parameters:
- MRB_BANK_NUM, 8, number of banks (any value 1..16, not necessarily a power of two)
- MRB_IND_WTH, 4, bank index width (must satisfy 2^MRB_IND_WTH >= MRB_BANK_NUM)
- MRB_ADDR_WTH, 9, per-bank word address width; depth = 2^MRB_ADDR_WTH
- MR_PROC_WTH, 8, element width in bits
- MR_PROC_H_PARAL, 8, horizontal lanes
- MR_PROC_V_PARAL, 8, vertical lanes
- MR_DATA_WTH, MR_PROC_WTH*MR_PROC_H_PARAL*MR_PROC_V_PARAL, word width (derived, not overridden)
- VMR_DATA_WTH, MR_DATA_WTH*MRB_BANK_NUM, vector-mode read width (derived)

Ports:
- clk_i  in  1  clock; the only clock
- rst_i  in  1  asynchronous active-high reset
- mpu_mrb__re_i  in  1  read request
- mpu_mrb__type_i  in  1  0 = scalar read (one bank), 1 = vector read (all banks, same address)
- mpu_mrb__rindex_i  in  MRB_IND_WTH  read bank index; ignored when type=1
- mpu_mrb__raddr_i  in  MRB_ADDR_WTH  read address
- mpu_mrb__rdata_o  out  MR_DATA_WTH  scalar read data
- mpu_mrb__rdata_act_o  out  1  scalar read data valid
- mpu_mrb__vmode_rdata_o  out  VMR_DATA_WTH  vector read data; bank i occupies bits [MR_DATA_WTH*i +: MR_DATA_WTH]
- mpu_mrb__vmode_rdata_act_o  out  1  vector read data valid
- ldmr_mrb__we_i  in  1  write request
- ldmr_mrb__windex_i  in  MRB_IND_WTH  write bank index
- ldmr_mrb__waddr_i  in  MRB_ADDR_WTH  write address
- ldmr_mrb__wdata_i  in  MR_DATA_WTH  write data; lane (h,v) occupies bits [MR_PROC_WTH*(h*MR_PROC_V_PARAL+v) +: MR_PROC_WTH]
- ldmr_mrb__wstrb_h_i  in  MR_PROC_H_PARAL  horizontal strobe
- ldmr_mrb__wstrb_v_i  in  MR_PROC_V_PARAL  vertical strobe
- mrb__err_o  out  1  sticky index-out-of-range flag
- mrb__err_clr_i  in  1  synchronous clear of mrb__err_o

## Operation
- **Write.** Lane (h,v) of bank windex at waddr is written iff we_i & wstrb_h_i[h] & wstrb_v_i[v]. Unstrobed lanes keep their old contents.
- **Scalar read.** Returns the full word of bank rindex at raddr.
- **Vector read.** Reads raddr from every bank in parallel.
- **Forwarding.** If a read and a write hit the same bank and address in the same request cycle, the read returns merged data: strobed lanes come from wdata, other lanes from the old RAM contents. Vector reads forward only for the written bank.
- **Out-of-range writes.** windex >= MRB_BANK_NUM with we_i=1: the write is dropped and mrb__err_o is set.
- **Out-of-range scalar reads.** rindex >= MRB_BANK_NUM with re_i=1 and type=0: rdata_o returns all zeros, rdata_act_o still pulses at the normal time, and mrb__err_o is set.
- **Error flag.** Set has priority over err_clr_i in the same cycle.
- **Act outputs are mode-gated.**
  - rdata_act_o pulses only for type=0 requests.
  - vmode_rdata_act_o pulses only for type=1 requests.
  - The data output of the mode not requested holds its previous value.
- **RAM initial state.** RAM contents are not reset and are undefined until written.

## Timing
- Pipeline stages:
  - Stage 0: request registered.
  - Stage 1: RAM read and forward compare.
  - Stage 2: output mux registered.
- Read issued at cycle t → data and act outputs valid at cycle t+3 (act high for exactly 1 cycle). Fully pipelined: one read per cycle.
- Write issued at t commits at the t+1 edge. A read issued at t+1 or later sees the new data; a read issued at t is served by forwarding.
- Reads and writes are independent: no backpressure, and no ready signals.
- Reset values: all outputs 0; the act pipeline and error flag are cleared.
- Reset mid-operation kills in-flight reads (no act after reset deasserts). A write captured in stage 0 at reset assertion is discarded.

## Structure
- Shared package mrb_pkg holds:
  - the lane-index helper function;
  - the pipeline depth localparam MRB_RD_LAT = 3.
- Natural sub-module: mrb_bank, one per bank, instantiated MRB_BANK_NUM times. Each is a simple dual-port inferred RAM with per-lane write enables (H*V enables) and a registered read port.
- The top level contains:
  - the request registers;
  - index decode and range check;
  - forward merge;
  - the output mux;
  - the act shift register;
  - the error flag.

## Test plan
- Write bank 2 addr 5 with 0xA5-pattern data, full strobes; scalar read bank 2 addr 5 at t → rdata_o = the pattern and rdata_act_o=1 at exactly t+3.
- Write all-0x11 to bank 1 addr 0, then write 0xFF with wstrb_h=0x01, wstrb_v=0x80; read back → only lane (0,7) = 0xFF, all other lanes 0x11.
- Same-cycle write 0x22 (full strobes) and read of bank 3 addr 7, old value 0x00 → returns 0x22 at t+3. Repeat with half strobes → merged data returned.
- Fill banks 0..7 addr 9 with value i+1; issue vector read of addr 9 → vmode_rdata_o bank i slice = i+1, vmode_rdata_act_o=1 at t+3, rdata_act_o stays 0.
- With MRB_BANK_NUM=6: write windex 7 → no bank changes and mrb__err_o=1. Scalar read index 6 → zeros with act. Assert err_clr_i → flag returns to 0.
- Issue 3 back-to-back reads, assert rst_i at t+1 → all outputs 0, no act pulse after release. Reads after reset behave normally.
